// File: rtl/rv32_wb_arb_pkg.sv
// Shared types and default widths for the RV32 writeback arbiter and its LL FIFO.
package rv32_wb_arb_pkg;

  localparam int DEF_WORD_WTH    = 32;
  localparam int DEF_REG_INX_WTH = 5;
  localparam int DEF_WB_SRC_NUM  = 4;
  localparam int DEF_WB_SEL_WTH  = 2;
  localparam int DEF_LL_DEPTH    = 4;
  localparam int DEF_LL_PTR_WTH  = 2;
  localparam int DEF_MAX_WAIT    = 8;
  localparam int DEF_WAIT_WTH    = 4;

  typedef enum logic [DEF_WB_SEL_WTH-1:0] {
    WB_SRC_ALU  = 2'd0,
    WB_SRC_LOAD = 2'd1,
    WB_SRC_PC4  = 2'd2,
    WB_SRC_IMM  = 2'd3
  } wb_src_e;

  localparam logic [DEF_REG_INX_WTH-1:0] REG_X0 = '0;

endpackage

// File: rtl/rv32_wb_ll_fifo.sv
// Small synchronous FIFO for long-latency results; head is visible combinationally.
module rv32_wb_ll_fifo
  import rv32_wb_arb_pkg::*;
#(
  parameter int WORD_WTH    = DEF_WORD_WTH,
  parameter int REG_INX_WTH = DEF_REG_INX_WTH,
  parameter int LL_DEPTH    = DEF_LL_DEPTH,
  parameter int LL_PTR_WTH  = DEF_LL_PTR_WTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic [WORD_WTH-1:0]    push_data_i,
  input  logic [REG_INX_WTH-1:0] push_inx_i,
  input  logic                   pop_i,
  output logic [WORD_WTH-1:0]    head_data_o,
  output logic [REG_INX_WTH-1:0] head_inx_o,
  output logic [LL_PTR_WTH:0]    cnt_o,
  output logic                   full_o,
  output logic                   empty_o
);

  logic [WORD_WTH-1:0]    data_mem [LL_DEPTH];
  logic [REG_INX_WTH-1:0] inx_mem  [LL_DEPTH];

  logic [LL_PTR_WTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [LL_PTR_WTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [LL_PTR_WTH:0]   cnt_q, cnt_d;

  // Power-of-two depth lets the pointers wrap by natural overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q + LL_PTR_WTH'(push_i);
    rd_ptr_d = rd_ptr_q + LL_PTR_WTH'(pop_i);
    cnt_d    = cnt_q + (LL_PTR_WTH+1)'(push_i) - (LL_PTR_WTH+1)'(pop_i);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) begin
      data_mem[wr_ptr_q] <= push_data_i;
      inx_mem[wr_ptr_q]  <= push_inx_i;
    end
  end

  assign head_data_o = data_mem[rd_ptr_q];
  assign head_inx_o  = inx_mem[rd_ptr_q];
  assign cnt_o       = cnt_q;
  assign full_o      = (cnt_q == (LL_PTR_WTH+1)'(LL_DEPTH));
  assign empty_o     = (cnt_q == '0);

endmodule

// File: rtl/rv32_wb_arb.sv
// Writeback stage: pipeline source mux, buffered LL channel and write-port arbitration
// with an anti-starvation stall request.
module rv32_wb_arb
  import rv32_wb_arb_pkg::*;
#(
  parameter int WORD_WTH    = DEF_WORD_WTH,
  parameter int REG_INX_WTH = DEF_REG_INX_WTH,
  parameter int WB_SRC_NUM  = DEF_WB_SRC_NUM,
  parameter int WB_SEL_WTH  = DEF_WB_SEL_WTH,
  parameter int LL_DEPTH    = DEF_LL_DEPTH,
  parameter int LL_PTR_WTH  = DEF_LL_PTR_WTH,
  parameter int MAX_WAIT    = DEF_MAX_WAIT,
  parameter int WAIT_WTH    = DEF_WAIT_WTH
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           wb_RegW_EN_i,
  input  logic [WB_SEL_WTH-1:0]          wb_RegW_sel_i,
  input  logic [WB_SRC_NUM*WORD_WTH-1:0] wb_wdata_i,
  input  logic [REG_INX_WTH-1:0]         wb_rd_inx_i,
  input  logic                           ll_valid_i,
  input  logic [WORD_WTH-1:0]            ll_data_i,
  input  logic [REG_INX_WTH-1:0]         ll_rd_inx_i,
  output logic                           ll_ready_o,
  output logic                           wb_stall_o,
  output logic                           wb_RegW_EN_o,
  output logic [WORD_WTH-1:0]            wb_RegW_data_o,
  output logic [REG_INX_WTH-1:0]         wb_rd_inx_o,
  output logic [WORD_WTH-1:0]            wb_exu_fd,
  output logic                           wb_RegW_EN_har_o,
  output logic [REG_INX_WTH-1:0]         wb_rd_inx_har_o,
  output logic                           wb_src_ll_o,
  output logic [LL_PTR_WTH:0]            ll_cnt_o
);

  logic [WORD_WTH-1:0] src_data [WB_SRC_NUM];
  logic [WORD_WTH-1:0] pipe_data;

  for (genvar gi = 0; gi < WB_SRC_NUM; gi++) begin : g_src
    assign src_data[gi] = wb_wdata_i[gi*WORD_WTH +: WORD_WTH];
  end

  always_comb begin
    pipe_data = src_data[int'(WB_SRC_ALU)];
    if (int'(wb_RegW_sel_i) < WB_SRC_NUM) pipe_data = src_data[wb_RegW_sel_i];
  end

  logic                   push, pop, full, empty;
  logic [WORD_WTH-1:0]    head_data;
  logic [REG_INX_WTH-1:0] head_inx;
  logic                   pipe_req, ll_grant, pipe_grant;

  assign pipe_req   = wb_RegW_EN_i & (wb_rd_inx_i != REG_INX_WTH'(REG_X0));
  assign ll_ready_o = rst & ~full;
  // x0 LL results complete the handshake but are dropped here.
  assign push       = ll_valid_i & ll_ready_o & (ll_rd_inx_i != REG_INX_WTH'(REG_X0));
  assign ll_grant   = rst & ~empty & (~pipe_req | wb_stall_o);
  assign pipe_grant = rst & pipe_req & ~ll_grant;
  assign pop        = ll_grant;

  rv32_wb_ll_fifo #(
    .WORD_WTH   (WORD_WTH),
    .REG_INX_WTH(REG_INX_WTH),
    .LL_DEPTH   (LL_DEPTH),
    .LL_PTR_WTH (LL_PTR_WTH)
  ) u_ll_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (push),
    .push_data_i(ll_data_i),
    .push_inx_i (ll_rd_inx_i),
    .pop_i      (pop),
    .head_data_o(head_data),
    .head_inx_o (head_inx),
    .cnt_o      (ll_cnt_o),
    .full_o     (full),
    .empty_o    (empty)
  );

  logic [WAIT_WTH-1:0] wait_q, wait_d;
  logic                stall_q, stall_d;

  // Stall is raised one cycle early so the head is written on the MAX_WAIT-th waiting cycle.
  always_comb begin
    wait_d  = wait_q;
    stall_d = stall_q;
    if (empty || pop) begin
      wait_d = '0;
    end else if (wait_q != WAIT_WTH'(MAX_WAIT)) begin
      wait_d = wait_q + 1'b1;
    end
    if (pop) begin
      stall_d = 1'b0;
    end else if (!empty && (wait_q >= WAIT_WTH'(MAX_WAIT - 2))) begin
      stall_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wait_q  <= '0;
      stall_q <= 1'b0;
    end else begin
      wait_q  <= wait_d;
      stall_q <= stall_d;
    end
  end

  assign wb_stall_o = stall_q;

  always_comb begin
    wb_RegW_EN_o   = 1'b0;
    wb_src_ll_o    = 1'b0;
    wb_RegW_data_o = pipe_data;
    wb_rd_inx_o    = wb_rd_inx_i;
    if (ll_grant) begin
      wb_RegW_EN_o   = 1'b1;
      wb_src_ll_o    = 1'b1;
      wb_RegW_data_o = head_data;
      wb_rd_inx_o    = head_inx;
    end else if (pipe_grant) begin
      wb_RegW_EN_o = 1'b1;
    end
  end

  assign wb_exu_fd        = wb_RegW_data_o;
  assign wb_RegW_EN_har_o = wb_RegW_EN_o;
  assign wb_rd_inx_har_o  = wb_rd_inx_o;

endmodule

// File: tb/tb_rv32_wb_arb.sv
// Randomized bench for rv32_wb_arb against a queue-based model of the writeback rules.
module tb_rv32_wb_arb;

  logic         clk = 1'b0;
  logic         rst;
  logic         wb_RegW_EN_i;
  logic [1:0]   wb_RegW_sel_i;
  logic [127:0] wb_wdata_i;
  logic [4:0]   wb_rd_inx_i;
  logic         ll_valid_i;
  logic [31:0]  ll_data_i;
  logic [4:0]   ll_rd_inx_i;
  logic         ll_ready_o, wb_stall_o, wb_RegW_EN_o, wb_RegW_EN_har_o, wb_src_ll_o;
  logic [31:0]  wb_RegW_data_o, wb_exu_fd;
  logic [4:0]   wb_rd_inx_o, wb_rd_inx_har_o;
  logic [2:0]   ll_cnt_o;

  always #5 clk = ~clk;

  rv32_wb_arb dut (
    .clk(clk), .rst(rst),
    .wb_RegW_EN_i(wb_RegW_EN_i), .wb_RegW_sel_i(wb_RegW_sel_i),
    .wb_wdata_i(wb_wdata_i), .wb_rd_inx_i(wb_rd_inx_i),
    .ll_valid_i(ll_valid_i), .ll_data_i(ll_data_i), .ll_rd_inx_i(ll_rd_inx_i),
    .ll_ready_o(ll_ready_o), .wb_stall_o(wb_stall_o),
    .wb_RegW_EN_o(wb_RegW_EN_o), .wb_RegW_data_o(wb_RegW_data_o),
    .wb_rd_inx_o(wb_rd_inx_o), .wb_exu_fd(wb_exu_fd),
    .wb_RegW_EN_har_o(wb_RegW_EN_har_o), .wb_rd_inx_har_o(wb_rd_inx_har_o),
    .wb_src_ll_o(wb_src_ll_o), .ll_cnt_o(ll_cnt_o)
  );

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  rd;
  } ll_ent_t;

  ll_ent_t ll_q[$];
  int      head_age = 0;
  bit      stall_m  = 0;
  int      n_vec    = 0;
  int      n_err    = 0;
  int      cyc      = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  // One clock: compare outputs mid-cycle, then advance the model at the edge.
  task automatic step();
    bit          preq, g_ll, g_pipe, acc, was_empty;
    logic [31:0] e_data;
    logic [4:0]  e_rd;
    @(negedge clk);
    preq   = wb_RegW_EN_i && (wb_rd_inx_i != 0);
    g_ll   = rst && (ll_q.size() > 0) && (!preq || stall_m);
    g_pipe = rst && preq && !g_ll;
    e_data = g_ll ? ll_q[0].data : wb_wdata_i[wb_RegW_sel_i*32 +: 32];
    e_rd   = g_ll ? ll_q[0].rd : wb_rd_inx_i;
    check_val("en",    32'(wb_RegW_EN_o), 32'(g_ll || g_pipe));
    check_val("src",   32'(wb_src_ll_o),  32'(g_ll));
    check_val("data",  wb_RegW_data_o,    e_data);
    check_val("rd",    32'(wb_rd_inx_o),  32'(e_rd));
    check_val("fwd",   wb_exu_fd,         e_data);
    check_val("har",   {26'd0, wb_RegW_EN_har_o, wb_rd_inx_har_o}, {26'd0, g_ll || g_pipe, e_rd});
    check_val("ready", 32'(ll_ready_o),   32'(rst && ll_q.size() < 4));
    check_val("cnt",   32'(ll_cnt_o),     32'(ll_q.size()));
    check_val("stall", 32'(wb_stall_o),   32'(stall_m));
    @(posedge clk);
    if (!rst) begin
      ll_q.delete();
      head_age = 0;
      stall_m  = 0;
    end else begin
      was_empty = (ll_q.size() == 0);
      acc = ll_valid_i && (ll_q.size() < 4) && (ll_rd_inx_i != 0);
      if (g_ll) void'(ll_q.pop_front());
      if (acc) ll_q.push_back('{data: ll_data_i, rd: ll_rd_inx_i});
      if (g_ll || was_empty) begin
        head_age = 0;
        if (g_ll) stall_m = 0;
      end else begin
        head_age = (head_age < 8) ? head_age + 1 : 8;
        if (head_age >= 7) stall_m = 1;
      end
    end
    cyc++;
    #1;
  endtask

  task automatic set_pipe(input logic en, input logic [1:0] sel, input logic [4:0] rd);
    wb_RegW_EN_i  = en;
    wb_RegW_sel_i = sel;
    wb_rd_inx_i   = rd;
  endtask

  task automatic set_ll(input logic v, input logic [31:0] d, input logic [4:0] rd);
    ll_valid_i  = v;
    ll_data_i   = d;
    ll_rd_inx_i = rd;
  endtask

  initial begin
    rst = 1'b0;
    wb_wdata_i = {32'h3333_0003, 32'h0000_1004, 32'h1111_0001, 32'h0000_00A0};
    set_pipe(1'b0, 2'd0, 5'd0);
    set_ll(1'b0, 32'd0, 5'd0);
    #1;
    repeat (2) step();
    rst = 1'b1;

    set_pipe(1'b1, 2'd2, 5'd5);
    step();

    set_pipe(1'b1, 2'd0, 5'd0);
    set_ll(1'b1, 32'h0000_DEAD, 5'd0);
    step();
    set_ll(1'b0, 32'd0, 5'd0);
    step();

    set_pipe(1'b0, 2'd0, 5'd0);
    set_ll(1'b1, 32'hCAFE_0001, 5'd7);
    step();
    set_ll(1'b0, 32'd0, 5'd0);
    step();

    set_pipe(1'b1, 2'd1, 5'd3);
    set_ll(1'b1, 32'h0000_0900, 5'd9);
    step();
    set_ll(1'b0, 32'd0, 5'd0);
    repeat (12) step();

    for (int k = 0; k < 6; k++) begin
      set_ll(1'b1, 32'h0000_0A00 + 32'(k), 5'(10 + k));
      step();
    end

    set_ll(1'b0, 32'd0, 5'd0);
    for (int k = 0; k < 40 && !(stall_m && ll_q.size() >= 2); k++) step();
    check_val("stall_before_rst", 32'(wb_stall_o), 32'd1);
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;

    for (int k = 0; k < 3000; k++) begin
      if (!stall_m) begin
        set_pipe($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
                 ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31)));
        wb_wdata_i = {$urandom, $urandom, $urandom, $urandom};
      end
      set_ll($urandom_range(0, 2) == 0, $urandom,
             ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31)));
      rst = ($urandom_range(0, 299) != 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
